// File: rtl/ysyx_23060136_axi_rd_arbiter.sv
// ysyx_23060136_axi_rd_arbiter
//
// Two-client AXI4 read-channel arbiter. Merges instruction-fetch (IFU) and
// load (LSU) read requests onto a single AXI master read port. Only one
// transaction is in flight at a time. The R beat is routed back to whichever
// client owns the current grant. The block also drives the slave's
// inst_fetch sideband, so the memory model can tag the read as a fetch or a
// load.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   ifu_ar*/ifu_r*         IFU read client (size fixed to 4 bytes, 3'b010)
//   lsu_ar*/lsu_r*         LSU read client (size supplied, rresp returned)
//   io_master_ar*          AR channel to the slave, fields buffered at grant
//   io_master_r*           R channel from the slave, passed through with no latency
//   inst_fetch             high while the granted transaction belongs to IFU
//
// Configuration:
//   YSYX_23060136_ARB_RR_EN  defined   : round-robin on ties. A last-grant
//                                         bit is reset to LSU, so IFU wins
//                                         the first tie after reset.
//                            undefined : fixed priority, LSU wins every tie.

module ysyx_23060136_axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_arready,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [2:0]        lsu_arsize,
  output logic              lsu_arready,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,

  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [2:0]        io_master_arsize,
  output logic [3:0]        io_master_arid,
  output logic [7:0]        io_master_arlen,
  output logic [1:0]        io_master_arburst,
  input  logic              io_master_rvalid,
  output logic              io_master_rready,
  input  logic [DATA_W-1:0] io_master_rdata,
  input  logic [1:0]        io_master_rresp,
  input  logic              io_master_rlast,

  output logic              inst_fetch
);

  localparam logic [2:0] IFU_SIZE = 3'b010;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  // AR fields captured at grant time and held until the next grant
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
  } ar_req_t;

  state_t  state;
  logic    grant_ifu;
  ar_req_t ar_q;

  // Tie-break preference: 1 -> IFU wins when both clients request together
  logic prefer_ifu;
`ifdef YSYX_23060136_ARB_RR_EN
  logic last_ifu;
  assign prefer_ifu = ~last_ifu;
`else
  assign prefer_ifu = 1'b0;
`endif

  logic ifu_win, lsu_win, can_grant;
  assign ifu_win   = ifu_arvalid & (~lsu_arvalid | prefer_ifu);
  assign lsu_win   = lsu_arvalid & ~ifu_win;
  // Gate with rst so a client never sees a handshake that the FSM drops
  assign can_grant = (state == IDLE) & ~rst;

  assign ifu_arready = can_grant & ifu_win;
  assign lsu_arready = can_grant & lsu_win;

  logic r_sel_ready, r_done;
  assign r_sel_ready = grant_ifu ? ifu_rready : lsu_rready;
  assign r_done      = io_master_rvalid & io_master_rready & io_master_rlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_ifu <= 1'b0;
      ar_q      <= '0;
`ifdef YSYX_23060136_ARB_RR_EN
      last_ifu  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ifu_win | lsu_win) begin
            grant_ifu <= ifu_win;
            ar_q.addr <= ifu_win ? ifu_araddr : lsu_araddr;
            ar_q.size <= ifu_win ? IFU_SIZE : lsu_arsize;
            state     <= ADDR;
`ifdef YSYX_23060136_ARB_RR_EN
            last_ifu  <= ifu_win;
`endif
          end
        end
        ADDR: if (io_master_arready) state <= DATA;
        DATA: if (r_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // AR channel: fields come from registers; valid decodes from the state register
  assign io_master_arvalid = (state == ADDR);
  assign io_master_araddr  = ar_q.addr;
  assign io_master_arsize  = ar_q.size;
  assign io_master_arid    = 4'd0;
  assign io_master_arlen   = 8'd0;
  assign io_master_arburst = 2'b01;

  // Held steady from grant through the last R beat, so the sideband is
  // stable while the slave performs its AR handshake
  assign inst_fetch = (state != IDLE) & grant_ifu;

  // R channel: combinational steering, zero added latency
  assign io_master_rready = (state == DATA) & r_sel_ready;
  assign ifu_rvalid       = (state == DATA) &  grant_ifu & io_master_rvalid;
  assign lsu_rvalid       = (state == DATA) & ~grant_ifu & io_master_rvalid;
  assign ifu_rdata        = io_master_rdata;
  assign lsu_rdata        = io_master_rdata;
  assign lsu_rresp        = io_master_rresp;

endmodule

// File: tb/tb_ysyx_23060136_axi_rd_arbiter.sv
// Testbench for ysyx_23060136_axi_rd_arbiter: a directed sequence followed by
// random client and slave traffic. A transaction-level model tracks the
// transaction that is in flight and predicts every output on every cycle.
module tb_ysyx_23060136_axi_rd_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic clk, rst;
  logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [ADDR_W-1:0] ifu_araddr;
  logic [DATA_W-1:0] ifu_rdata;
  logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [ADDR_W-1:0] lsu_araddr;
  logic [2:0] lsu_arsize;
  logic [DATA_W-1:0] lsu_rdata;
  logic [1:0] lsu_rresp;
  logic io_master_arvalid, io_master_arready;
  logic [ADDR_W-1:0] io_master_araddr;
  logic [2:0] io_master_arsize;
  logic [3:0] io_master_arid;
  logic [7:0] io_master_arlen;
  logic [1:0] io_master_arburst;
  logic io_master_rvalid, io_master_rready, io_master_rlast;
  logic [DATA_W-1:0] io_master_rdata;
  logic [1:0] io_master_rresp;
  logic inst_fetch;

  ysyx_23060136_axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
    .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arsize(io_master_arsize),
    .io_master_arid(io_master_arid), .io_master_arlen(io_master_arlen),
    .io_master_arburst(io_master_arburst), .io_master_rvalid(io_master_rvalid),
    .io_master_rready(io_master_rready), .io_master_rdata(io_master_rdata),
    .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
    .inst_fetch(inst_fetch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: is a read in flight, has its AR been issued,
  // who owns it, and which AR fields are buffered
  bit m_busy, m_issued, m_owner_ifu, m_last_ifu;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0] m_size;
  bit acc_ifu, acc_lsu;
  int done_ifu, done_lsu;

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_owner_ifu = 0; m_last_ifu = 0;
    m_addr = '0; m_size = '0;
  endtask

  task automatic idle_in();
    rst = 0;
    ifu_arvalid = 0; ifu_araddr = '0; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_arsize = '0; lsu_rready = 0;
    io_master_arready = 0; io_master_rvalid = 0; io_master_rlast = 1;
    io_master_rdata = '0; io_master_rresp = '0;
  endtask

  // Called #1 after a rising edge with the inputs already set. It checks the
  // outputs, advances the model across the next edge, and returns #1 after it.
  task automatic step();
    bit win_ifu, grant, sel_rr, r_hs;
    // A well-behaved slave drives R only once it has taken the address
    io_master_rvalid = io_master_rvalid & m_issued;
    #1;
    if (ifu_arvalid && lsu_arvalid) begin
`ifdef YSYX_23060136_ARB_RR_EN
      win_ifu = !m_last_ifu;
`else
      win_ifu = 0;
`endif
    end else begin
      win_ifu = ifu_arvalid;
    end
    grant  = !rst && !m_busy && (ifu_arvalid || lsu_arvalid);
    sel_rr = m_owner_ifu ? ifu_rready : lsu_rready;
    chk("ifu_arready", ifu_arready, grant && win_ifu);
    chk("lsu_arready", lsu_arready, grant && !win_ifu);
    chk("m_arvalid", io_master_arvalid, m_busy && !m_issued);
    chk("m_araddr", io_master_araddr, m_addr);
    chk("m_arsize", io_master_arsize, m_size);
    chk("inst_fetch", inst_fetch, m_busy && m_owner_ifu);
    chk("m_rready", io_master_rready, m_issued && sel_rr);
    chk("ifu_rvalid", ifu_rvalid, m_issued && m_owner_ifu && io_master_rvalid);
    chk("lsu_rvalid", lsu_rvalid, m_issued && !m_owner_ifu && io_master_rvalid);
    chk("ifu_rdata", ifu_rdata, io_master_rdata);
    chk("lsu_rdata", lsu_rdata, io_master_rdata);
    chk("lsu_rresp", lsu_rresp, io_master_rresp);
    acc_ifu = grant && win_ifu;
    acc_lsu = grant && !win_ifu;
    r_hs = m_issued && io_master_rvalid && sel_rr && io_master_rlast;
    if (rst) model_reset();
    else if (grant) begin
      m_busy = 1; m_owner_ifu = win_ifu; m_last_ifu = win_ifu;
      m_addr = win_ifu ? ifu_araddr : lsu_araddr;
      m_size = win_ifu ? 3'b010 : lsu_arsize;
    end else if (m_busy && !m_issued && io_master_arready) m_issued = 1;
    else if (r_hs) begin
      if (m_owner_ifu) done_ifu++; else done_lsu++;
      m_busy = 0; m_issued = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit ih, lh;
    model_reset();
    done_ifu = 0; done_lsu = 0;
    idle_in();
    rst = 1;
    @(posedge clk); #1;
    step();
    rst = 1; step();
    chk("arid", io_master_arid, 4'd0);
    chk("arlen", io_master_arlen, 8'd0);
    chk("arburst", io_master_arburst, 2'b01);

    // IFU only at the reset vector, with a slave that responds immediately
    idle_in(); ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; step();
    idle_in(); io_master_arready = 1; step();
    idle_in(); ifu_rready = 1; io_master_rvalid = 1;
    io_master_rdata = 64'h1122_3344_5566_7788; step();

    // LSU only, doubleword access, error response
    idle_in(); lsu_arvalid = 1; lsu_araddr = 32'h8000_0100; lsu_arsize = 3'b011; step();
    idle_in(); io_master_arready = 1; step();
    idle_in(); lsu_rready = 1; io_master_rvalid = 1; io_master_rresp = 2'b10;
    io_master_rdata = 64'hdead_beef_cafe_f00d; step();

    // Sustained tie against an always-ready slave
    for (int i = 0; i < 18; i++) begin
      idle_in();
      ifu_arvalid = 1; ifu_araddr = 32'h8000_1000 + i;
      lsu_arvalid = 1; lsu_araddr = 32'h8000_2000 + i; lsu_arsize = 3'b001;
      io_master_arready = 1; io_master_rvalid = 1; ifu_rready = 1; lsu_rready = 1;
      io_master_rdata = {32'h0, 32'(i)};
      step();
    end

    // Back-pressure on AR, then on R, with an LSU request arriving mid-DATA
    idle_in(); ifu_arvalid = 1; ifu_araddr = 32'h8000_0040; step();
    for (int i = 0; i < 5; i++) begin idle_in(); step(); end
    idle_in(); io_master_arready = 1; step();
    for (int i = 0; i < 3; i++) begin
      idle_in(); io_master_rvalid = 1; lsu_arvalid = 1; lsu_araddr = 32'h8000_0200;
      lsu_arsize = 3'b010; step();
    end
    idle_in(); io_master_rvalid = 1; ifu_rready = 1; lsu_arvalid = 1;
    lsu_araddr = 32'h8000_0200; lsu_arsize = 3'b010; step();
    idle_in(); lsu_arvalid = 1; lsu_araddr = 32'h8000_0200; lsu_arsize = 3'b010; step();
    idle_in(); io_master_arready = 1; step();
    idle_in(); io_master_rvalid = 1; lsu_rready = 1; step();

    // Reset pulsed while the AR is still pending, then a normal IFU read
    idle_in(); ifu_arvalid = 1; ifu_araddr = 32'h8000_0080; step();
    idle_in(); rst = 1; step();
    idle_in(); step();
    idle_in(); ifu_arvalid = 1; ifu_araddr = 32'h8000_0084; step();
    idle_in(); io_master_arready = 1; step();
    idle_in(); io_master_rvalid = 1; ifu_rready = 1; io_master_rdata = 64'h55; step();

    // Random traffic: a client holds an unaccepted request most of the time
    ih = 0; lh = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [ADDR_W-1:0] ia, la;
      logic [2:0] ls;
      ia = ifu_araddr; la = lsu_araddr; ls = lsu_arsize;
      idle_in();
      if (ih && !acc_ifu && $urandom_range(9) != 0) begin
        ifu_arvalid = 1; ifu_araddr = ia;
      end else begin
        ifu_arvalid = ($urandom_range(2) != 0); ifu_araddr = $urandom;
      end
      if (lh && !acc_lsu && $urandom_range(9) != 0) begin
        lsu_arvalid = 1; lsu_araddr = la; lsu_arsize = ls;
      end else begin
        lsu_arvalid = ($urandom_range(2) != 0); lsu_araddr = $urandom;
        lsu_arsize = 3'($urandom_range(3));
      end
      ih = ifu_arvalid; lh = lsu_arvalid;
      ifu_rready = ($urandom_range(3) != 0);
      lsu_rready = ($urandom_range(3) != 0);
      io_master_arready = $urandom_range(1) != 0;
      io_master_rvalid = ($urandom_range(4) < 3);
      io_master_rlast = ($urandom_range(4) != 0);
      io_master_rdata = {$urandom, $urandom};
      io_master_rresp = 2'($urandom_range(3));
      rst = ($urandom_range(199) == 0);
      if (rst) begin ih = 0; lh = 0; end
      step();
    end

    checks++;
    if (done_ifu < 20 || done_lsu < 20) begin
      errors++;
      $display("FAIL progress ifu_done=%0d lsu_done=%0d need>=20 each", done_ifu, done_lsu);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_23060136_axi_rd_arbiter.md
# ysyx_23060136_axi_rd_arbiter

Two-client AXI4 read-channel arbiter upstream of the memory slave model. Merges instruction-fetch (IFU) and load (LSU) read requests onto one AXI master read port, holds one outstanding transaction, and routes the R beat back to the requester. Drives the slave's `inst_fetch` sideband so the DPI read is tagged correctly. LSU writes bypass this block.

## Interface
- `ADDR_W`, 32, address width of all AR paths
- `DATA_W`, 64, read data width of all R paths
- `clk` input 1 system clock, rising edge
- `rst` input 1 synchronous reset, active-high
- `ifu_arvalid` input 1 IFU read request
- `ifu_araddr` input ADDR_W IFU request address
- `ifu_arready` output 1 IFU request accepted
- `ifu_rvalid` output 1 IFU response valid
- `ifu_rready` input 1 IFU accepts response
- `ifu_rdata` output DATA_W IFU response data
- `lsu_arvalid` input 1 LSU read request
- `lsu_araddr` input ADDR_W LSU request address
- `lsu_arsize` input 3 LSU transfer size (AXI encoding)
- `lsu_arready` output 1 LSU request accepted
- `lsu_rvalid` output 1 LSU response valid
- `lsu_rready` input 1 LSU accepts response
- `lsu_rdata` output DATA_W LSU response data
- `lsu_rresp` output 2 LSU response code, from slave
- `io_master_arvalid` output 1 AR valid to slave
- `io_master_arready` input 1 AR ready from slave
- `io_master_araddr` output ADDR_W buffered address
- `io_master_arsize` output 3 buffered size; IFU requests use 3'b010
- `io_master_arid` / `io_master_arlen` / `io_master_arburst` output 4/8/2, constants 0 / 0 / 2'b01
- `io_master_rvalid` input 1 R valid from slave
- `io_master_rready` output 1 R ready to slave
- `io_master_rdata` input DATA_W R data
- `io_master_rresp` input 2 R response
- `io_master_rlast` input 1 R last beat
- `inst_fetch` output 1 high while the granted transaction belongs to IFU

## Operation
- FSM states: IDLE, ADDR, DATA. Reset → IDLE.
- IDLE: if any `*_arvalid`, select a winner. Assert the winner's `*_arready` combinationally in this cycle. Latch grant, address, and size (IFU: 3'b010). Next state is ADDR. With no request, stay in IDLE.
- ADDR: `io_master_arvalid`=1 with buffered fields. On `io_master_arvalid & io_master_arready`, go to DATA.
- DATA:
  - `io_master_rready` = granted client's `rready`.
  - Granted client's `rvalid` = `io_master_rvalid`. Non-granted client's `rvalid` = 0.
  - On `io_master_rvalid & io_master_rready & io_master_rlast`, go to IDLE.
- `ifu_rdata`/`lsu_rdata` are combinational copies of `io_master_rdata` (ungated). `lsu_rresp` is a copy of `io_master_rresp`.
- `inst_fetch` = (ADDR|DATA) & grant==IFU. It is stable across the slave's AR handshake.
- Single outstanding transaction. A client's `arready` is never high outside IDLE.

## Timing
- Reset values: all `*_arready`, `*_rvalid`, `io_master_arvalid`, `io_master_rready`, `inst_fetch` = 0. `io_master_araddr`/`io_master_arsize` = 0.
- Client AR handshake in cycle N → `io_master_arvalid` high in cycle N+1.
- R path adds zero latency: client `rvalid` and data follow the slave in the same cycle.
- Minimum loop: IDLE→ADDR→DATA→IDLE = 3 cycles with a slave that responds immediately. A back-to-back request is accepted in the IDLE cycle that follows the last R handshake.
- Simultaneous IFU+LSU requests in IDLE: resolved by the priority rule under Configuration.
- Request deasserted before grant: nothing is issued. No AXI stability obligation applies to clients until their `arready` is seen.
- Reset mid-transaction: next cycle is IDLE with outputs at reset values. The in-flight response is dropped; the slave is reset together with this block.

## Configuration
- `YSYX_23060136_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - A 1-bit last-grant register, reset to LSU, is updated on each grant.
  - On a tie, the client not granted last wins, so IFU wins the first tie after reset.
- Not defined: fixed priority, LSU wins every tie; the last-grant register is absent.

## Test plan
- IFU only, `ifu_araddr`=0x8000_0000:
  - `ifu_arready` is high in the request cycle.
  - Next cycle: `io_master_araddr`=0x8000_0000, `arsize`=3'b010, `inst_fetch`=1.
  - The slave's `rdata` appears on `ifu_rdata` with `ifu_rvalid`=1 and `lsu_rvalid`=0.
- LSU only, `lsu_araddr`=0x8000_0100, `lsu_arsize`=3'b011: `io_master_arsize`=3'b011 and `inst_fetch`=0. A slave `rresp`=2'b10 appears on `lsu_rresp`.
- Tie, IFU and LSU requesting together:
  - Without the macro: LSU is granted on every tie.
  - With the macro: first grant IFU, then LSU, strictly alternating while both are held.
- Backpressure:
  - `io_master_arready` held 0 for 5 cycles: `io_master_arvalid` stays 1 and `araddr` is stable.
  - `ifu_rready`=0 for 3 cycles: `io_master_rready`=0, and the FSM stays in DATA until release.
- Second request during DATA: `lsu_arvalid` is asserted mid-transaction and `lsu_arready` stays 0. It is accepted in the IDLE cycle right after the IFU R handshake.
- `rst` pulsed while in ADDR: next cycle all outputs are 0, and a new IFU request is then served normally.
